fetch_decode_unit: RTL and testbench

Instruction fetch and field-decode stage that sits directly upstream of the multi-cycle control unit. It owns the program counter (PC) and the instruction register (IR), and it drives `opcode` into the control unit. It consumes the control unit's `pc_write`, `stall`, `branch`, `jump` and `jr` strobes to sequence and redirect the PC. It also raises the LDW/SDW odd-register exception and a sticky fetch fault.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/imm_extender.sv | 14 +
 rtl/fetch_decode_unit.sv | 88 ++++++++
 tb/tb_fetch_decode_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, instruction field positions and widths for the fetch/decode stage.
package cpu_pkg;
   localparam int PC_W      = 32;
   localparam int REG_IDX_W = 4;
   localparam int OPC_W     = 6;
   localparam int OPC_LSB   = 26;
   localparam int RD_LSB    = 22;
   localparam int RS_LSB    = 18;
   localparam int RT_LSB    = 14;
   localparam int IMM_W     = 14;
   localparam int OFF_W     = 26;
   localparam logic [OPC_W-1:0] OP_OR   = 6'd0;
   localparam logic [OPC_W-1:0] OP_ADD  = 6'd1;
   localparam logic [OPC_W-1:0] OP_SUB  = 6'd2;
   localparam logic [OPC_W-1:0] OP_AND  = 6'd3;
   localparam logic [OPC_W-1:0] OP_ORI  = 6'd4;
   localparam logic [OPC_W-1:0] OP_ADDI = 6'd5;
   localparam logic [OPC_W-1:0] OP_LD   = 6'd6;
   localparam logic [OPC_W-1:0] OP_ST   = 6'd7;
   localparam logic [OPC_W-1:0] OP_LDW  = 6'd8;
   localparam logic [OPC_W-1:0] OP_SDW  = 6'd9;
   localparam logic [OPC_W-1:0] OP_JR   = 6'd10;
   localparam logic [OPC_W-1:0] OP_BZ   = 6'd11;
   localparam logic [OPC_W-1:0] OP_BGZ  = 6'd12;
   localparam logic [OPC_W-1:0] OP_BLZ  = 6'd13;
   localparam logic [OPC_W-1:0] OP_J    = 6'd14;
   localparam logic [OPC_W-1:0] OP_CLL  = 6'd15;
   typedef enum logic {RUN, HALT} state_e;
endpackage

// File: rtl/imm_extender.sv
// imm_extender: builds the 32-bit immediate from IR; ORI zero-extends, J/CLL use the 26-bit offset.
module imm_extender
   import cpu_pkg::*;
(
   input  logic [PC_W-1:0]  ir,
   input  logic [OPC_W-1:0] opcode,
   output logic [PC_W-1:0]  imm_ext
);
   always_comb begin
      imm_ext = (opcode == OP_ORI) ? {{(PC_W-IMM_W){1'b0}}, ir[IMM_W-1:0]} :
                (opcode == OP_J || opcode == OP_CLL) ? {{(PC_W-OFF_W){ir[OFF_W-1]}}, ir[OFF_W-1:0]} :
                {{(PC_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
   end
endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: owns PC and IR, decodes instruction fields and sequences/redirects the PC.
module fetch_decode_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter int          IMEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pc_write,
   input  logic                 stall,
   input  logic                 branch,
   input  logic                 jump,
   input  logic                 jr,
   input  logic [PC_W-1:0]      rs_data,
   output logic [PC_W-1:0]      imem_addr,
   input  logic [PC_W-1:0]      imem_rdata,
   output logic [OPC_W-1:0]     opcode,
   output logic [REG_IDX_W-1:0] rd,
   output logic [REG_IDX_W-1:0] rs,
   output logic [REG_IDX_W-1:0] rt,
   output logic [PC_W-1:0]      imm_ext,
   output logic [PC_W-1:0]      return_addr,
   output logic [PC_W-1:0]      pc,
   output logic [PC_W-1:0]      instr_pc,
   output logic                 ldw_exception,
   output logic                 fetch_fault,
   output logic                 halted
);
   localparam logic [PC_W-1:0] DEPTH = PC_W'(IMEM_DEPTH);
   logic [PC_W-1:0] pc_q, pc_d, ir_q, ir_d, instr_pc_q, instr_pc_d;
   logic            ldw_q, ldw_d;
   state_e          state_q, state_d;
   logic [OPC_W-1:0] fetch_op;
   imm_extender u_imm (
      .ir      (ir_q),
      .opcode  (opcode),
      .imm_ext (imm_ext)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         instr_pc_q <= RESET_PC;
         ldw_q      <= 1'b0;
         state_q    <= RUN;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         instr_pc_q <= instr_pc_d;
         ldw_q      <= ldw_d;
         state_q    <= state_d;
      end
   end
   // Branch and J/CLL share one adder: both targets are instr_pc + imm_ext.
   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      instr_pc_d = instr_pc_q;
      ldw_d      = ldw_q;
      state_d    = state_q;
      fetch_op   = imem_rdata[OPC_LSB +: OPC_W];
      if (state_q == RUN && !stall) begin
         if (jr)
            pc_d = rs_data;
         else if (jump || branch)
            pc_d = instr_pc_q + imm_ext;
         else if (pc_write && pc_q < DEPTH) begin
            ir_d       = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 1'b1;
            ldw_d      = (fetch_op == OP_LDW || fetch_op == OP_SDW) && imem_rdata[RD_LSB];
         end else if (pc_write)
            state_d = HALT;
      end
   end
   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign instr_pc      = instr_pc_q;
   assign opcode        = ir_q[OPC_LSB +: OPC_W];
   assign rd            = ir_q[RD_LSB +: REG_IDX_W];
   assign rs            = ir_q[RS_LSB +: REG_IDX_W];
   assign rt            = ir_q[RT_LSB +: REG_IDX_W];
   assign return_addr   = instr_pc_q + 1'b1;
   assign ldw_exception = ldw_q;
   assign fetch_fault   = state_q == HALT;
   assign halted        = state_q == HALT;
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: directed vectors for fetch, redirects, LDW/SDW exception, fetch fault and async reset.
module tb_fetch_decode_unit;
   logic        clk = 1'b0, reset = 1'b0;
   logic        pc_write = 0, stall = 0, branch = 0, jump = 0, jr = 0;
   logic [31:0] rs_data = 0, imem_rdata = 0;
   logic [31:0] imem_addr, imm_ext, return_addr, pc, instr_pc;
   logic [5:0]  opcode;
   logic [3:0]  rd, rs, rt;
   logic        ldw_exception, fetch_fault, halted;
   logic        pw4 = 0, jump4 = 0;
   logic [31:0] imem_addr4, imm_ext4, return_addr4, pc4, instr_pc4;
   logic [5:0]  opcode4;
   logic [3:0]  rd4, rs4, rt4;
   logic        ldw4, fault4, halted4;
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   fetch_decode_unit dut (
      .clk(clk), .reset(reset), .pc_write(pc_write), .stall(stall), .branch(branch),
      .jump(jump), .jr(jr), .rs_data(rs_data), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm_ext(imm_ext), .return_addr(return_addr),
      .pc(pc), .instr_pc(instr_pc), .ldw_exception(ldw_exception), .fetch_fault(fetch_fault),
      .halted(halted)
   );
   fetch_decode_unit #(.IMEM_DEPTH(4)) dut4 (
      .clk(clk), .reset(reset), .pc_write(pw4), .stall(1'b0), .branch(1'b0),
      .jump(jump4), .jr(1'b0), .rs_data(rs_data), .imem_addr(imem_addr4), .imem_rdata(imem_rdata),
      .opcode(opcode4), .rd(rd4), .rs(rs4), .rt(rt4), .imm_ext(imm_ext4), .return_addr(return_addr4),
      .pc(pc4), .instr_pc(instr_pc4), .ldw_exception(ldw4), .fetch_fault(fault4),
      .halted(halted4)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic fetch(input logic [31:0] w);
      imem_rdata = w;
      pc_write   = 1'b1;
      step();
      pc_write   = 1'b0;
   endtask
   initial begin
      #3;
      chk("rst_pc", pc, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_opcode", {26'd0, opcode}, 0);
      chk("rst_imm_ext", imm_ext, 0);
      chk("rst_return_addr", return_addr, 1);
      chk("rst_flags", {29'd0, ldw_exception, fetch_fault, halted}, 0);
      #9 reset = 1'b1;
      step();
      fetch({6'd1, 4'd1, 4'd2, 4'd3, 14'd0});
      fetch({6'd4, 4'd1, 4'd2, 4'd0, 14'h3FFF});
      chk("ori_zext", imm_ext, 32'h0000_3FFF);
      chk("ori_rd_rs", {24'd0, rd, rs}, 32'h12);
      fetch({6'd2, 4'd5, 4'd6, 4'd7, 14'd0});
      chk("seq_pc", pc, 3);
      chk("seq_instr_pc", instr_pc, 2);
      chk("seq_opcode", {26'd0, opcode}, 2);
      chk("seq_fields", {20'd0, rd, rs, rt}, 32'h567);
      chk("seq_imem_addr", imem_addr, 3);
      rs_data = 10; jr = 1'b1; step(); jr = 1'b0;
      chk("jr10_pc", pc, 10);
      chk("jr10_ir_kept", {26'd0, opcode}, 2);
      fetch({6'd11, 4'd0, 4'd1, 4'd0, 14'h3FFE});
      chk("bz_instr_pc", instr_pc, 10);
      chk("bz_imm_sext", imm_ext, 32'hFFFF_FFFE);
      branch = 1'b1; step(); branch = 1'b0;
      chk("bz_pc", pc, 8);
      chk("bz_ir_kept", {26'd0, opcode}, 11);
      chk("bz_instr_pc_kept", instr_pc, 10);
      rs_data = 5; jr = 1'b1; step(); jr = 1'b0;
      fetch({6'd15, 26'd20});
      chk("cll_return_addr", return_addr, 6);
      chk("cll_imm", imm_ext, 20);
      jump = 1'b1; step(); jump = 1'b0;
      chk("cll_pc", pc, 25);
      imem_rdata = {6'd1, 26'd0};
      rs_data = 32'h40; jr = 1'b1; pc_write = 1'b1; step(); jr = 1'b0; pc_write = 1'b0;
      chk("jr40_pc", pc, 32'h40);
      chk("jr_beats_fetch_ipc", instr_pc, 5);
      chk("jr_beats_fetch_op", {26'd0, opcode}, 15);
      fetch({6'd8, 4'd3, 22'd0});
      chk("ldw_odd_exc", {31'd0, ldw_exception}, 1);
      fetch({6'd9, 4'd4, 22'd0});
      chk("sdw_even_exc", {31'd0, ldw_exception}, 0);
      stall = 1'b1;
      fetch({6'd8, 4'd3, 22'd0});
      stall = 1'b0;
      chk("stall_pc", pc, 32'h42);
      chk("stall_op", {26'd0, opcode}, 9);
      chk("stall_exc", {31'd0, ldw_exception}, 0);
      imem_rdata = {6'd1, 26'd0};
      pw4 = 1'b1;
      repeat (4) step();
      chk("d4_pc", pc4, 4);
      chk("d4_no_fault", {31'd0, fault4}, 0);
      step();
      chk("d4_fault", {30'd0, fault4, halted4}, 3);
      chk("d4_fault_pc", pc4, 4);
      chk("d4_fault_ipc", instr_pc4, 3);
      jump4 = 1'b1;
      repeat (2) step();
      pw4 = 1'b0; jump4 = 1'b0;
      chk("d4_halt_pc", pc4, 4);
      chk("d4_halt_ipc", instr_pc4, 3);
      rs_data = 32'h77; jr = 1'b1; step();
      chk("jr77_pc", pc, 32'h77);
      #2 reset = 1'b0;
      #1;
      chk("async_pc", pc, 0);
      chk("async_ipc", instr_pc, 0);
      chk("async_opcode", {26'd0, opcode}, 0);
      chk("async_ret", return_addr, 1);
      chk("async_d4_flags", {30'd0, fault4, halted4}, 0);
      chk("async_d4_pc", pc4, 0);
      jr = 1'b0;
      #2 reset = 1'b1;
      step();
      chk("post_rst_pc", pc, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
